// File: rtl/multi_word_add_seq_pkg.sv
// Shared types and constants for the sequential multi-word adder.
// Slice width, FSM states and the per-slice overflow helper.
package multi_word_add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Signed overflow = carry out XOR carry into the msb.
  function automatic logic slice_ovf(
    input logic [SLICE_W:0] res,
    input logic             a_msb,
    input logic             b_msb
  );
    return res[SLICE_W] ^ (res[SLICE_W-1] ^ a_msb ^ b_msb);
  endfunction

endpackage

// File: rtl/multi_word_add_seq_adder.sv
// 16-bit conditional-sum adder with carry-in, 17-bit result.
// Every stage merges pairs of blocks, each precomputed for cin=0 and cin=1.
module adderblock16bit
  import multi_word_add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W:0]   sum_o
);

  logic [SLICE_W-1:0] s0, s1, c0, c1;
  logic [SLICE_W-1:0] n0, n1, m0, m1;
  logic [3:0]         hi, lo;

  always_comb begin
    s0 = a_i ^ b_i;
    s1 = ~(a_i ^ b_i);
    c0 = a_i & b_i;
    c1 = a_i | b_i;
    n0 = '0;
    n1 = '0;
    m0 = '0;
    m1 = '0;
    hi = '0;
    lo = '0;
    for (int lv = 0; lv < 4; lv++) begin
      n0 = s0;
      n1 = s1;
      m0 = '0;
      m1 = '0;
      for (int j = 0; j < (8 >> lv); j++) begin
        lo = 4'(2 * j);
        for (int t = 0; t < (1 << lv); t++) begin
          hi = 4'((2 * j + 1) * (1 << lv) + t);
          n0[hi] = c0[lo] ? s1[hi] : s0[hi];
          n1[hi] = c1[lo] ? s1[hi] : s0[hi];
        end
        m0[4'(j)] = c0[lo] ? c1[lo + 4'd1] : c0[lo + 4'd1];
        m1[4'(j)] = c1[lo] ? c1[lo + 4'd1] : c0[lo + 4'd1];
      end
      s0 = n0;
      s1 = n1;
      c0 = m0;
      c1 = m1;
    end
    sum_o = cin_i ? {c1[0], s1} : {c0[0], s0};
  end

endmodule

// File: rtl/multi_word_add_seq.sv
// Sequential WORDS x 16-bit adder with valid/ready handshake.
// One slice per cycle through a shared conditional-sum adder.
module multi_word_add_seq
  import multi_word_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [SLICE_W-1:0] a_q [WORDS];
  logic [SLICE_W-1:0] a_d [WORDS];
  logic [SLICE_W-1:0] b_q [WORDS];
  logic [SLICE_W-1:0] b_d [WORDS];
  logic [SLICE_W-1:0] sum_q [WORDS];
  logic [SLICE_W-1:0] sum_d [WORDS];
  logic [SLICE_W-1:0] a_w [WORDS];
  logic [SLICE_W-1:0] b_w [WORDS];
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   add_res;
  logic               accept;

  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      a_w[k] = a[k*SLICE_W +: SLICE_W];
      b_w[k] = b[k*SLICE_W +: SLICE_W];
    end
  end

  for (genvar k = 0; k < WORDS; k++) begin : g_sum
    assign sum[k*SLICE_W +: SLICE_W] = sum_q[k];
  end

  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  assign a_sl = a_q[idx_q];
  assign b_sl = b_q[idx_q];

  adderblock16bit u_add (
    .a_i   (a_sl),
    .b_i   (b_sl),
    .cin_i (carry_q),
    .sum_o (add_res)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: ;
      S_ADD: begin
        sum_d[idx_q] = add_res[SLICE_W-1:0];
        carry_d      = add_res[SLICE_W];
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          idx_d   = '0;
          cout_d  = add_res[SLICE_W];
          ovf_d   = slice_ovf(add_res, a_sl[SLICE_W-1],
                              b_sl[SLICE_W-1]);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A new request overrides the DONE->IDLE release on the same edge.
    if (accept) begin
      state_d = S_ADD;
      a_d     = a_w;
      b_d     = b_w;
      carry_d = cin;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_multi_word_add_seq.sv
// Randomized bench for multi_word_add_seq against an arithmetic model.
// Directed corner cases, stalls, mid-operation reset, then random traffic.
module tb_multi_word_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
  localparam int NRAND = 3000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  multi_word_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  int errs   = 0;
  int checks = 0;
  int rem    = -1;
  int n_take = 0;
  logic [W+1:0] exp_res = '0;

  task automatic chk(input string tag, input logic [W+1:0] got,
                     input logic [W+1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {t[W], v, t[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0: r = {W{1'b1}};
      1: r = '0;
      2: r = {1'b0, {(W-1){1'b1}}};
      3: r = {1'b1, {(W-1){1'b0}}};
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  // One clock: drive at the falling edge, check, advance the model.
  task automatic step(input logic iv, input logic [W-1:0] na,
                      input logic [W-1:0] nb, input logic nc,
                      input logic ordy);
    logic exp_rdy;
    logic take;
    logic acc;
    @(negedge clk);
    in_valid  = iv;
    a         = na;
    b         = nb;
    cin       = nc;
    out_ready = ordy;
    #1;
    exp_rdy = (rem < 0) || (rem == 0 && ordy);
    chk("out_valid", {{(W+1){1'b0}}, out_valid},
        {{(W+1){1'b0}}, rem == 0});
    chk("in_ready", {{(W+1){1'b0}}, in_ready},
        {{(W+1){1'b0}}, exp_rdy});
    if (rem == 0) chk("result", {cout, ovf, sum}, exp_res);
    take = (rem == 0) && ordy;
    acc  = iv && exp_rdy;
    if (rem > 0) rem--;
    else if (take) begin
      rem = -1;
      n_take++;
    end
    if (acc) begin
      exp_res = model(na, nb, nc);
      rem     = WORDS;
    end
  endtask

  task automatic run_dir(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic [W+1:0] exp);
    step(1'b1, x, y, c, 1'b1);
    exp_res = exp;
    for (int i = 0; i < WORDS + 1; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {{(W+1){1'b0}}, out_valid}, '0);
    chk({tag, "_res"}, {cout, ovf, sum}, '0);
    chk({tag, "_ready"}, {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
  endtask

  initial begin
    int cyc;
    #3;
    chk_reset_vals("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    run_dir({W{1'b1}}, '0, 1'b1, {1'b1, 1'b0, {W{1'b0}}});
    run_dir(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
            {1'b0, 1'b1, 64'h8000_0000_0000_0000});
    run_dir(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
            {1'b0, 1'b0, 64'h0001_0000_0001_0000});

    // Stall in DONE while new requests are offered, then same-edge accept.
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    for (int i = 0; i < WORDS; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'(i % 2), rnd_op(), rnd_op(), 1'($urandom), 1'b0);
    step(1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1, 1'b1);
    for (int i = 0; i < WORDS + 1; i++) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset after two ADD edges discards the operation.
    step(1'b1, {W{1'b1}}, {W{1'b1}}, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    rem = -1;
    @(negedge clk);
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    run_dir(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
            {1'b1, 1'b1, 64'h0});

    // Reset while holding a result in DONE.
    step(1'b1, 64'h5, 64'h6, 1'b0, 1'b0);
    for (int i = 0; i < WORDS + 2; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_done");
    rem = -1;
    @(negedge clk);
    rst_n = 1'b1;

    n_take = 0;
    cyc    = 0;
    while (n_take < NRAND && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom),
           $urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("random_done", {{(W+1){1'b0}}, n_take >= NRAND},
        {{(W+1){1'b0}}, 1'b1});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
